// File: rtl/rob_commit_unit_pkg.sv
// Shared commit definitions for the reorder-buffer commit unit.
// Optional performance counters are enabled with ROB_COMMIT_PERF_CNT_EN.
`ifndef MAX_NUM_OF_COMMITS
`define MAX_NUM_OF_COMMITS 4
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package rob_commit_unit_pkg;

    typedef enum logic [1:0] {
        none_commit             = 2'd0,
        reg_commit              = 2'd1,
        branch_commit_taken     = 2'd2,
        branch_commit_not_taken = 2'd3
    } commit_type_t;

    localparam int COMMIT_W = `MAX_NUM_OF_COMMITS;

    function automatic logic is_taken(input commit_type_t t);
        return (t == branch_commit_taken);
    endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// Commit-slot bundle driven by the ROB toward the retire stage.
interface COMMIT_IF #(parameter int VALUE_W = `INST_ADDR_WIDTH);
    import rob_commit_unit_pkg::*;

    logic [COMMIT_W-1:0]               commit_valid;
    commit_type_t [COMMIT_W-1:0]       commit_type;
    logic [COMMIT_W-1:0][VALUE_W-1:0]  commit_value;

    modport master (output commit_valid, output commit_type, output commit_value);
    modport slave  (input  commit_valid, input  commit_type, input  commit_value);
endinterface

// File: rtl/rob_commit_unit_entry_array.sv
// ROB entry storage: one allocation port, one writeback port, per-entry free
// strobes and one read port per commit slot.
module rob_entry_array
    import rob_commit_unit_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int VALUE_W = `INST_ADDR_WIDTH,
    parameter int NR      = `MAX_NUM_OF_COMMITS
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              alloc_en,
    input  logic [$clog2(DEPTH)-1:0]          alloc_idx,
    input  logic                              wb_en,
    input  logic [$clog2(DEPTH)-1:0]          wb_idx,
    input  commit_type_t                      wb_type,
    input  logic [VALUE_W-1:0]                wb_value,
    input  logic [DEPTH-1:0]                  free_mask,
    input  logic [NR-1:0][$clog2(DEPTH)-1:0]  rd_idx,
    output logic [NR-1:0]                     rd_valid,
    output logic [NR-1:0]                     rd_complete,
    output commit_type_t [NR-1:0]             rd_type,
    output logic [NR-1:0][VALUE_W-1:0]        rd_value
);
    logic [DEPTH-1:0]               valid_r;
    logic [DEPTH-1:0]               complete_r;
    commit_type_t [DEPTH-1:0]       type_r;
    logic [DEPTH-1:0][VALUE_W-1:0]  value_r;

    // Entry state update; a wb only lands on an entry allocated at an earlier edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r    <= '0;
            complete_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_r[i]  <= none_commit;
                value_r[i] <= '0;
            end
        end else if (clear) begin
            valid_r    <= '0;
            complete_r <= '0;
        end else begin
            if (alloc_en) begin
                valid_r[alloc_idx]    <= 1'b1;
                complete_r[alloc_idx] <= 1'b0;
            end
            if (wb_en && valid_r[wb_idx]) begin
                complete_r[wb_idx] <= 1'b1;
                type_r[wb_idx]     <= wb_type;
                value_r[wb_idx]    <= wb_value;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (free_mask[i]) begin
                    valid_r[i]    <= 1'b0;
                    complete_r[i] <= 1'b0;
                end
            end
        end
    end

    // Commit-slot read ports.
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            rd_valid[r]    = valid_r[rd_idx[r]];
            rd_complete[r] = complete_r[rd_idx[r]];
            rd_type[r]     = type_r[rd_idx[r]];
            rd_value[r]    = value_r[rd_idx[r]];
        end
    end
endmodule

// File: rtl/rob_commit_unit.sv
// In-order reorder-buffer commit unit: allocation at tail, writeback marking,
// multi-slot in-order commit from head. Define ROB_COMMIT_PERF_CNT_EN for counters.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int VALUE_W   = `INST_ADDR_WIDTH
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    output logic [$clog2(ROB_DEPTH)-1:0]  alloc_tag,
    input  logic                          wb_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]  wb_tag,
    input  commit_type_t                  wb_type,
    input  logic [VALUE_W-1:0]            wb_value,
    input  logic                          flush,
    COMMIT_IF.master                      commit_if,
    output logic                          rob_empty
`ifdef ROB_COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]                   commit_cnt,
    output logic [31:0]                   taken_cnt
`endif
);
    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int NC    = `MAX_NUM_OF_COMMITS;
    localparam int CNT_W = $clog2(NC + 1);

    logic [PTR_W-1:0]             head_r;
    logic [PTR_W-1:0]             tail_r;
    logic                         full_s;
    logic                         alloc_fire_s;
    logic [NC-1:0][IDX_W-1:0]     rd_idx_s;
    logic [NC-1:0]                rd_valid_s;
    logic [NC-1:0]                rd_complete_s;
    commit_type_t [NC-1:0]        rd_type_s;
    logic [NC-1:0][VALUE_W-1:0]   rd_value_s;
    logic [NC-1:0]                slot_valid_s;
    commit_type_t [NC-1:0]        slot_type_s;
    logic [NC-1:0][VALUE_W-1:0]   slot_value_s;
    logic [CNT_W-1:0]             n_commit_s;
    logic                         taken_commit_s;
    logic [ROB_DEPTH-1:0]         free_mask_s;

    // Full/empty purely from registered pointers, so freed slots are not reused in the same cycle.
    assign full_s       = (head_r[IDX_W] != tail_r[IDX_W]) &&
                          (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]);
    assign rob_empty    = (head_r == tail_r);
    assign alloc_ready  = !full_s;
    assign alloc_tag    = tail_r[IDX_W-1:0];
    assign alloc_fire_s = alloc_valid && alloc_ready && !flush;

    rob_entry_array #(
        .DEPTH   (ROB_DEPTH),
        .VALUE_W (VALUE_W),
        .NR      (NC)
    ) u_entries (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .alloc_en    (alloc_fire_s),
        .alloc_idx   (tail_r[IDX_W-1:0]),
        .wb_en       (wb_valid),
        .wb_idx      (wb_tag),
        .wb_type     (wb_type),
        .wb_value    (wb_value),
        .free_mask   (free_mask_s),
        .rd_idx      (rd_idx_s),
        .rd_valid    (rd_valid_s),
        .rd_complete (rd_complete_s),
        .rd_type     (rd_type_s),
        .rd_value    (rd_value_s)
    );

    // Slot i reads entry head+i (modulo depth).
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            rd_idx_s[i] = head_r[IDX_W-1:0] + IDX_W'(i);
        end
    end

    // Commit select: contiguous complete run from head, cut after the first taken branch.
    always_comb begin
        logic chain;
        chain          = 1'b1;
        n_commit_s     = '0;
        taken_commit_s = 1'b0;
        free_mask_s    = '0;
        for (int i = 0; i < NC; i++) begin
            if (chain && rd_valid_s[i] && rd_complete_s[i]) begin
                slot_valid_s[i]           = 1'b1;
                slot_type_s[i]            = rd_type_s[i];
                slot_value_s[i]           = rd_value_s[i];
                n_commit_s                = n_commit_s + CNT_W'(1);
                free_mask_s[rd_idx_s[i]]  = 1'b1;
                if (is_taken(rd_type_s[i])) begin
                    taken_commit_s = 1'b1;
                    chain          = 1'b0;
                end else begin
                    chain          = 1'b1;
                end
            end else begin
                slot_valid_s[i] = 1'b0;
                slot_type_s[i]  = none_commit;
                slot_value_s[i] = '0;
                chain           = 1'b0;
            end
        end
    end

    assign commit_if.commit_valid = slot_valid_s;
    assign commit_if.commit_type  = slot_type_s;
    assign commit_if.commit_value = slot_value_s;

    // Head/tail pointers; flush wins over allocation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r <= '0;
            tail_r <= '0;
        end else if (flush) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            head_r <= head_r + PTR_W'(n_commit_s);
            if (alloc_fire_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
        end
    end

`ifdef ROB_COMMIT_PERF_CNT_EN
    logic [31:0] commit_cnt_r;
    logic [31:0] taken_cnt_r;

    // Free-running commit statistics, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_cnt_r <= 32'd0;
            taken_cnt_r  <= 32'd0;
        end else begin
            commit_cnt_r <= commit_cnt_r + 32'(n_commit_s);
            taken_cnt_r  <= taken_cnt_r + {31'd0, taken_commit_s};
        end
    end

    assign commit_cnt = commit_cnt_r;
    assign taken_cnt  = taken_cnt_r;
`endif
endmodule

// File: tb/tb_rob_commit_unit.sv
// Randomized bench for rob_commit_unit against a queue-based ROB reference model.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    localparam int DEPTH = 16;
    localparam int NC    = COMMIT_W;
    localparam int VW    = 32;

    typedef struct {
        logic [3:0]   tag;
        bit           done;
        commit_type_t typ;
        logic [31:0]  val;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [3:0]   alloc_tag;
    logic         wb_valid;
    logic [3:0]   wb_tag;
    commit_type_t wb_type;
    logic [31:0]  wb_value;
    logic         flush;
    logic         rob_empty;
`ifdef ROB_COMMIT_PERF_CNT_EN
    logic [31:0]  commit_cnt;
    logic [31:0]  taken_cnt;
`endif

    ent_t    rob_q[$];
    int      next_tag;
    int      checks;
    int      errors;
    longint  exp_commits;
    longint  exp_taken;

    COMMIT_IF #(.VALUE_W(VW)) cif();

    rob_commit_unit #(.ROB_DEPTH(DEPTH), .VALUE_W(VW)) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_type     (wb_type),
        .wb_value    (wb_value),
        .flush       (flush),
        .commit_if   (cif),
        .rob_empty   (rob_empty)
`ifdef ROB_COMMIT_PERF_CNT_EN
        ,
        .commit_cnt  (commit_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle: drive inputs, compare against model, clock, advance model.
    task automatic step(input bit av, input bit wv, input logic [3:0] wt,
                        input commit_type_t ty, input logic [31:0] v, input bit fl);
        int   n;
        int   tk;
        bit   stop;
        bit   ok;
        bit   ready;
        ent_t e;
        alloc_valid = av;
        wb_valid    = wv;
        wb_tag      = wt;
        wb_type     = ty;
        wb_value    = v;
        flush       = fl;
        #1;
        ready = (rob_q.size() < DEPTH);
        check_eq("alloc_ready", 64'(alloc_ready), 64'(ready));
        check_eq("alloc_tag", 64'(alloc_tag), 64'(next_tag));
        check_eq("rob_empty", 64'(rob_empty), 64'(rob_q.size() == 0));
        n = 0;
        tk = 0;
        stop = 1'b0;
        for (int i = 0; i < NC; i++) begin
            ok = !stop && (i < rob_q.size()) && rob_q[i].done;
            check_eq($sformatf("slot%0d_valid", i), 64'(cif.commit_valid[i]), 64'(ok));
            check_eq($sformatf("slot%0d_type", i), 64'(cif.commit_type[i]),
                     ok ? 64'(rob_q[i].typ) : 64'd0);
            check_eq($sformatf("slot%0d_value", i), 64'(cif.commit_value[i]),
                     ok ? 64'(rob_q[i].val) : 64'd0);
            if (ok) begin
                n++;
                if (rob_q[i].typ == branch_commit_taken) begin
                    tk++;
                    stop = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
`ifdef ROB_COMMIT_PERF_CNT_EN
        check_eq("commit_cnt", 64'(commit_cnt), 64'(exp_commits[31:0]));
        check_eq("taken_cnt", 64'(taken_cnt), 64'(exp_taken[31:0]));
`endif
        @(posedge clk);
        exp_commits += n;
        exp_taken   += tk;
        if (fl) begin
            rob_q.delete();
            next_tag = 0;
        end else begin
            for (int i = 0; i < n; i++) void'(rob_q.pop_front());
            if (wv) begin
                for (int k = 0; k < rob_q.size(); k++) begin
                    if (rob_q[k].tag == wt) begin
                        e = rob_q[k];
                        e.done = 1'b1;
                        e.typ  = ty;
                        e.val  = v;
                        rob_q[k] = e;
                    end
                end
            end
            if (av && ready) begin
                e.tag  = 4'(next_tag);
                e.done = 1'b0;
                e.typ  = none_commit;
                e.val  = 32'd0;
                rob_q.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, none_commit, 32'd0, 1'b0);
    endtask

    task automatic alloc();
        step(1'b1, 1'b0, 4'd0, none_commit, 32'd0, 1'b0);
    endtask

    task automatic wb(input logic [3:0] t, input commit_type_t ty, input logic [31:0] v);
        step(1'b0, 1'b1, t, ty, v, 1'b0);
    endtask

    // Asynchronous reset with immediate output checks, then release after one edge.
    task automatic do_reset();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        wb_tag      = 4'd0;
        wb_type     = none_commit;
        wb_value    = 32'd0;
        flush       = 1'b0;
        reset       = 1'b1;
        #2;
        check_eq("rst_commit_valid", 64'(cif.commit_valid), 64'd0);
        check_eq("rst_commit_type", 64'(|cif.commit_type), 64'd0);
        check_eq("rst_commit_value", 64'(|cif.commit_value), 64'd0);
        check_eq("rst_rob_empty", 64'(rob_empty), 64'd1);
        check_eq("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        check_eq("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        rob_q.delete();
        next_tag    = 0;
        exp_commits = 0;
        exp_taken   = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int r;
        logic [3:0] t;
        checks = 0;
        errors = 0;
        do_reset();

        // Out-of-order completion, then two commits together.
        repeat (3) alloc();
        wb(4'd1, reg_commit, 32'h0000_0011);
        wb(4'd0, reg_commit, 32'h0000_0010);
        idle();
        idle();
        alloc();

        // Fill to full, then free two entries and wrap the tail.
        do_reset();
        repeat (17) alloc();
        check_eq("full_ready", 64'(alloc_ready), 64'd0);
        wb(4'd0, reg_commit, 32'h0000_0100);
        wb(4'd1, reg_commit, 32'h0000_0101);
        idle();
        idle();
        alloc();

        // Taken branch stops the commit group; flush empties.
        do_reset();
        repeat (2) alloc();
        wb(4'd0, branch_commit_taken, 32'h0000_0040);
        wb(4'd1, reg_commit, 32'h0000_0041);
        step(1'b0, 1'b0, 4'd0, none_commit, 32'd0, 1'b1);
        idle();

        // Flush beats simultaneous alloc and writeback.
        repeat (2) alloc();
        step(1'b1, 1'b1, 4'd0, reg_commit, 32'h0000_0055, 1'b1);
        idle();
        idle();

        // Perf-style sequence: 4 commits with one taken branch, then flush.
        do_reset();
        repeat (4) alloc();
        wb(4'd0, reg_commit, 32'h1);
        wb(4'd1, branch_commit_not_taken, 32'h2);
        wb(4'd2, reg_commit, 32'h3);
        wb(4'd3, branch_commit_taken, 32'h4);
        idle();
        step(1'b0, 1'b0, 4'd0, none_commit, 32'd0, 1'b1);
        idle();

        // Reset with five entries in flight.
        repeat (5) alloc();
        wb(4'd5, reg_commit, 32'h77);
        wb(4'd6, reg_commit, 32'h78);
        do_reset();
        idle();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 399);
            if (r == 0) begin
                do_reset();
            end else begin
                if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
                    t = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
                else
                    t = 4'($urandom_range(0, DEPTH - 1));
                step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7), t,
                     commit_type_t'($urandom_range(1, 3)), $urandom, (r < 8));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
